// File: rtl/cpu_pkg.sv
// Shared pipeline definitions: ALU-control function codes and divider FSM states.
// DIV decode in the stall helper is present only when DIVIDER_SIGNED_EN is defined.
package cpu_pkg;

  localparam logic [5:0] MFHI = 6'd16;
  localparam logic [5:0] MFLO = 6'd18;
  localparam logic [5:0] DIV  = 6'd26;
  localparam logic [5:0] DIVU = 6'd27;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    RUN  = 1'b1
  } div_state_e;

  // Function codes that must wait for an in-flight division to finish.
  function automatic logic holds_on_busy(input logic [5:0] f);
`ifdef DIVIDER_SIGNED_EN
    return (f == DIVU) || (f == DIV) || (f == MFHI) || (f == MFLO);
`else
    return (f == DIVU) || (f == MFHI) || (f == MFLO);
`endif
  endfunction

endpackage

// File: rtl/divider_core.sv
// Unsigned restoring shift-subtract divider, one quotient bit per cycle.
// quotient/remainder carry the step result and are valid while last is high.
module divider_core
  import cpu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             last,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder
);

  localparam int CW = $clog2(WIDTH + 1);

  div_state_e       r_state;
  logic [WIDTH-1:0] r_q;
  logic [WIDTH-1:0] r_r;
  logic [WIDTH-1:0] r_d;
  logic [CW-1:0]    r_cnt;

  logic [WIDTH:0]   w_sh;
  logic [WIDTH+1:0] w_diff;
  logic             w_ge;
  logic [WIDTH-1:0] w_r_nxt;
  logic [WIDTH-1:0] w_q_nxt;

  // Shifted remainder is WIDTH+1 bits; the extra borrow bit decides the restore.
  assign w_sh    = {r_r, r_q[WIDTH-1]};
  assign w_diff  = {1'b0, w_sh} - {2'b00, r_d};
  assign w_ge    = ~w_diff[WIDTH+1];
  assign w_r_nxt = WIDTH'(w_ge ? w_diff[WIDTH:0] : w_sh);
  assign w_q_nxt = {r_q[WIDTH-2:0], w_ge};

  assign busy      = (r_state == RUN);
  assign last      = (r_state == RUN) && (r_cnt == CW'(WIDTH - 1));
  assign quotient  = w_q_nxt;
  assign remainder = w_r_nxt;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_q     <= '0;
      r_r     <= '0;
      r_d     <= '0;
      r_cnt   <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (start) begin
            r_q     <= dividend;
            r_d     <= divisor;
            r_r     <= '0;
            r_cnt   <= '0;
            r_state <= RUN;
          end
        end
        RUN: begin
          r_r   <= w_r_nxt;
          r_q   <= w_q_nxt;
          r_cnt <= r_cnt + 1'b1;
          if (last) r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

// File: rtl/divider_hilo.sv
// Execute-stage divide unit: DIVU start decode, HI/LO writeback, MFHI/MFLO reads, stall.
// Defining DIVIDER_SIGNED_EN adds signed DIV on the same unsigned core.
module divider_hilo
  import cpu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [5:0]       funct,
  input  logic [WIDTH-1:0] dataA,
  input  logic [WIDTH-1:0] dataB,
  output logic [WIDTH-1:0] result,
  output logic             busy,
  output logic             stall,
  output logic             done,
  output logic             dbz
);

  logic [5:0]       r_prev_funct;
  logic [WIDTH-1:0] r_hi;
  logic [WIDTH-1:0] r_lo;
  logic             r_done;
  logic             r_dbz;
  logic             r_zero_div;

  logic             w_busy;
  logic             w_last;
  logic             w_start;
  logic [WIDTH-1:0] w_opa;
  logic [WIDTH-1:0] w_opb;
  logic [WIDTH-1:0] w_quo;
  logic [WIDTH-1:0] w_rem;
  logic [WIDTH-1:0] w_lo_wb;
  logic [WIDTH-1:0] w_hi_wb;

  // Edge detect: a DIVU held across the whole operation starts only once.
  logic w_start_u;
  assign w_start_u = (funct == DIVU) && (r_prev_funct != DIVU) && !w_busy;

`ifdef DIVIDER_SIGNED_EN
  logic w_start_s;
  logic w_a_neg;
  logic w_b_neg;
  logic r_neg_q;
  logic r_neg_r;

  assign w_start_s = (funct == DIV) && (r_prev_funct != DIV) && !w_busy;
  assign w_start   = w_start_u | w_start_s;
  assign w_a_neg   = w_start_s & dataA[WIDTH-1];
  assign w_b_neg   = w_start_s & dataB[WIDTH-1];
  assign w_opa     = w_a_neg ? -dataA : dataA;
  assign w_opb     = w_b_neg ? -dataB : dataB;
  assign w_lo_wb   = r_neg_q ? -w_quo : w_quo;
  assign w_hi_wb   = r_neg_r ? -w_rem : w_rem;

  // Divide by zero keeps LO all-ones, so quotient sign fix is suppressed.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_neg_q <= 1'b0;
      r_neg_r <= 1'b0;
    end else if (w_start) begin
      r_neg_q <= (w_a_neg ^ w_b_neg) && (dataB != '0);
      r_neg_r <= w_a_neg;
    end
  end
`else
  assign w_start = w_start_u;
  assign w_opa   = dataA;
  assign w_opb   = dataB;
  assign w_lo_wb = w_quo;
  assign w_hi_wb = w_rem;
`endif

  divider_core #(.WIDTH(WIDTH)) u_core (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (w_start),
    .dividend  (w_opa),
    .divisor   (w_opb),
    .busy      (w_busy),
    .last      (w_last),
    .quotient  (w_quo),
    .remainder (w_rem)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_prev_funct <= '0;
      r_hi         <= '0;
      r_lo         <= '0;
      r_done       <= 1'b0;
      r_dbz        <= 1'b0;
      r_zero_div   <= 1'b0;
    end else begin
      r_prev_funct <= funct;
      r_done       <= w_last;
      if (w_start) begin
        r_dbz      <= 1'b0;
        r_zero_div <= (dataB == '0);
      end
      if (w_last) begin
        r_hi  <= w_hi_wb;
        r_lo  <= w_lo_wb;
        r_dbz <= r_zero_div;
      end
    end
  end

  always_comb begin
    result = '0;
    if (funct == MFHI)      result = r_hi;
    else if (funct == MFLO) result = r_lo;
  end

  assign busy  = w_busy;
  assign stall = w_busy && holds_on_busy(funct);
  assign done  = r_done;
  assign dbz   = r_dbz;

endmodule

// File: tb/tb_divider_hilo.sv
// Scoreboard bench for divider_hilo: expected done/dbz and MFHI/MFLO reads are queued
// by the stimulus and checked by an independent negedge monitor.
module tb_divider_hilo;

  localparam int W = 32;
  localparam logic [5:0] F_MFHI = 6'd16;
  localparam logic [5:0] F_MFLO = 6'd18;
  localparam logic [5:0] F_DIV  = 6'd26;
  localparam logic [5:0] F_DIVU = 6'd27;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic [5:0]   funct = '0;
  logic [W-1:0] dataA = '0;
  logic [W-1:0] dataB = '0;
  logic [W-1:0] result;
  logic         busy, stall, done, dbz;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  int           done_cyc_q[$];
  bit           done_dbz_q[$];
  logic [W-1:0] rd_q[$];

  divider_hilo #(.WIDTH(W)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .funct  (funct),
    .dataA  (dataA),
    .dataB  (dataB),
    .result (result),
    .busy   (busy),
    .stall  (stall),
    .done   (done),
    .dbz    (dbz)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic hold(input int n);
    repeat (n) tick();
  endtask

  // Start sample on the next edge; done is seen 33 cycles after the drive cycle.
  task automatic issue(input logic [5:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                       input bit expect_done, input bit exp_dbz);
    funct = op;
    dataA = a;
    dataB = b;
    if (expect_done) begin
      done_cyc_q.push_back(cyc + 33);
      done_dbz_q.push_back(exp_dbz);
    end
  endtask

  task automatic read(input logic [5:0] f, input logic [W-1:0] exp);
    funct = f;
    rd_q.push_back(exp);
    tick();
    funct = '0;
  endtask

  always @(negedge clk) begin
    if (done) begin
      if (done_cyc_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL done_unexpected: got done=1 expected no pulse (cycle %0d)", cyc);
      end else begin
        check("done_latency", W'(cyc), W'(done_cyc_q.pop_front()));
        check("done_dbz", W'(dbz), W'(done_dbz_q.pop_front()));
      end
    end
    if (funct == F_MFHI || funct == F_MFLO) begin
      if (rd_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL read_unexpected: got result=%h expected no read (cycle %0d)", result, cyc);
      end else begin
        check(funct == F_MFHI ? "mfhi" : "mflo", result, rd_q.pop_front());
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected $finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int busy_cnt;

    // reset state
    rst_n = 1'b0;
    hold(2);
    @(negedge clk);
    check("rst_busy", W'(busy), 0);
    check("rst_done", W'(done), 0);
    check("rst_dbz", W'(dbz), 0);
    check("rst_result", result, 0);
    tick();
    rst_n = 1'b1;
    tick();
    read(F_MFHI, 32'd0);
    read(F_MFLO, 32'd0);

    // 100/7 with DIVU held 40 cycles: one start only
    issue(F_DIVU, 32'd100, 32'd7, 1, 0);
    busy_cnt = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      busy_cnt += int'(busy);
      tick();
    end
    check("busy_cycles", W'(busy_cnt), 32);
    read(F_MFHI, 32'd2);
    read(F_MFLO, 32'd14);

    // divide by zero
    issue(F_DIVU, 32'd5, 32'd0, 1, 1);
    hold(35);
    funct = '0;
    read(F_MFLO, 32'hFFFF_FFFF);
    read(F_MFHI, 32'd5);
    @(negedge clk);
    check("dbz_holds", W'(dbz), 1);
    tick();

    // MFHI while busy: old HI (5) under stall, new HI (2) once busy falls
    issue(F_DIVU, 32'd100, 32'd7, 1, 0);
    hold(10);
    funct = F_MFHI;
    for (int i = 0; i < 24; i++) begin
      rd_q.push_back(i < 23 ? 32'd5 : 32'd2);
      @(negedge clk);
      check("stall_mfhi", W'(stall), (i < 23) ? 1 : 0);
      tick();
    end
    funct = '0;
    @(negedge clk);
    check("dbz_cleared", W'(dbz), 0);
    tick();

    // reset at iteration 16 of 0xFFFFFFFF/3 aborts without done
    issue(F_DIVU, 32'hFFFF_FFFF, 32'd3, 0, 0);
    hold(16);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    funct = '0;
    @(negedge clk);
    check("abort_busy", W'(busy), 0);
    check("abort_done", W'(done), 0);
    tick();
    read(F_MFHI, 32'd0);
    read(F_MFLO, 32'd0);
    hold(40);
    issue(F_DIVU, 32'hFFFF_FFFF, 32'd3, 1, 0);
    hold(35);
    funct = '0;
    read(F_MFLO, 32'h5555_5555);
    read(F_MFHI, 32'd0);

    // back-to-back: new DIVU edge in the done cycle
    issue(F_DIVU, 32'hFFFF_FFFF, 32'd1, 1, 0);
    hold(32);
    funct = '0;
    tick();
    issue(F_DIVU, 32'd9, 32'd4, 1, 0);
    @(negedge clk);
    check("b2b_done", W'(done), 1);
    tick();
    read(F_MFLO, 32'hFFFF_FFFF);
    read(F_MFHI, 32'd0);
    hold(33);
    read(F_MFLO, 32'd2);
    read(F_MFHI, 32'd1);

`ifdef DIVIDER_SIGNED_EN
    issue(F_DIV, 32'hFFFF_FFF9, 32'd2, 1, 0);
    hold(35);
    funct = '0;
    read(F_MFLO, 32'hFFFF_FFFD);
    read(F_MFHI, 32'hFFFF_FFFF);
    issue(F_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 1, 0);
    hold(35);
    funct = '0;
    read(F_MFLO, 32'h8000_0000);
    read(F_MFHI, 32'd0);
    issue(F_DIV, 32'hFFFF_FFF9, 32'd0, 1, 1);
    hold(35);
    funct = '0;
    read(F_MFLO, 32'hFFFF_FFFF);
    read(F_MFHI, 32'hFFFF_FFF9);
`endif

    hold(5);
    check("done_q_drained", W'(done_cyc_q.size()), 0);
    check("rd_q_drained", W'(rd_q.size()), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/divider_hilo.md
# divider_hilo

Multi-cycle 32-bit divide unit with HI/LO result registers, in the execute stage of the pipeline CPU directly downstream of the ALU control block. Consumes the 6-bit function code from ALU control plus both register operands. Runs a 32-iteration restoring shift-subtract division on DIVU, writes remainder to HI and quotient to LO, and serves MFHI/MFLO reads. Drives a stall toward the pipeline while a division is in flight.

## Interface
- WIDTH, 32, operand/result width; the iteration count equals WIDTH.
- clk  in  1  rising-edge clock.
- rst_n  in  1  synchronous, active-low reset.
- funct  in  6  function code from ALU control: DIVU=27, MFHI=16, MFLO=18 (DIV=26 with macro); all other values are ignored.
- dataA  in  WIDTH  dividend.
- dataB  in  WIDTH  divisor.
- result  out  WIDTH  HI when funct=MFHI, LO when funct=MFLO, else 0; combinational from the registers.
- busy  out  1  high while a division is in the RUN state.
- stall  out  1  busy AND funct ∈ {DIVU, MFHI, MFLO} (plus DIV with macro).
- done  out  1  one-cycle pulse in the cycle after HI/LO update.
- dbz  out  1  registered flag for the last division: divisor was zero; holds until the next start.

## Operation
- States: IDLE, RUN.
- Start detect: start = (funct==DIVU) AND previous-cycle funct≠DIVU AND state==IDLE. The previous-cycle funct is held in a registered copy. ALU control holds DIVU for the whole operation, so a held DIVU never restarts a division.
- IDLE→RUN on start: latch dividend into Q, divisor into D, clear partial remainder R, clear iteration counter, set busy, clear dbz.
- Each RUN cycle: {R,Q} shifted left 1. If shifted R ≥ D, then R -= D and Q[0]=1, else Q[0]=0. Counter increments.
- The RUN cycle where the counter reaches WIDTH writes HI=R and LO=Q. The next state is IDLE, and done pulses in the following cycle.
- Divide by zero needs no special path: the algorithm yields LO=all-ones and HI=dividend. dbz is set.
- A start during RUN is impossible because start requires IDLE. A new DIVU edge seen during RUN is dropped.
- MFHI/MFLO during RUN: result shows the old HI/LO. stall=1 forces upstream to hold until busy falls.
- Comparison uses WIDTH+1-bit subtract; no overflow exists for unsigned.

## Timing
- Reset values: HI=0, LO=0, state=IDLE, busy=0, done=0, dbz=0, counter=0, prev-funct=0. result follows HI/LO, so it reads 0.
- Edge E0 samples the start. busy is high after E0. Iterations occur on E1..E32, and HI/LO update on E32. busy falls and done=1 after E32.
- Total latency is 33 cycles from start sample to HI/LO valid.
- Reset asserted mid-RUN aborts the operation at that edge. HI/LO are cleared and no done pulse occurs.
- Back-to-back: a DIVU edge in the cycle done is high starts a new division.

## Configuration
- DIVIDER_SIGNED_EN defined: decode DIV (funct=26, 6'b011010) as a second start source with the same edge rule.
  - Operands are absolute-valued at start, and the same unsigned core runs.
  - At writeback, LO is negated if operand signs differ, and HI takes the sign of the dividend.
  - 0x80000000 / -1 gives LO=0x80000000, HI=0.
  - Divide by zero gives LO=all-ones and HI=dividend, with dbz set.
  - Latency is unchanged.
- Undefined: DIV is ignored like any unknown funct, and no sign logic is synthesized.

## Structure
- Shared package (cpu_pkg): funct constants DIVU, DIV, MFHI, MFLO, and the divider state enum {IDLE, RUN}.
- Sub-module divider_core: the R/Q/D registers, shift-subtract step, and iteration counter, with ports start, operands, busy, last, quotient, and remainder.
- divider_hilo owns the decode, edge detect, sign handling, HI/LO, and output muxing.

## Test plan
- Reset, then DIVU 100/7 held for 40 cycles: busy for 32 cycles, done pulse, HI=2, LO=14, latency 33, no second start.
- DIVU 5/0: LO=0xFFFFFFFF, HI=5, dbz=1.
- MFHI issued 10 cycles into a division: stall=1, result=old HI until busy falls. Afterwards result=new HI and stall=0.
- rst_n low at iteration 16 of 0xFFFFFFFF/3: HI=LO=0, busy=0, no done pulse. A fresh DIVU edge then completes with LO=0x55555555, HI=0.
- Back-to-back: 0xFFFFFFFF/1, then a DIVU edge on the done cycle for 9/4: LO=0xFFFFFFFF, HI=0, then LO=2, HI=1.
- With DIVIDER_SIGNED_EN: DIV -7/2 gives LO=0xFFFFFFFD, HI=0xFFFFFFFF. DIV 0x80000000/0xFFFFFFFF gives LO=0x80000000, HI=0.
